// File: rtl/mips_load_run_ctrl.sv
// Load/run/dump sequencer for the pipe_MIPS32 core.
// Streams a program into instruction memory, preloads Rk = k, runs the core
// until HALT retires or the cycle budget expires, then streams registers out.
// Every output is a register or decodes only state_q, so nothing an input does
// reaches an output in the same cycle. An imem write therefore appears on the
// outputs in the cycle after its ld_valid/ld_ready transfer.
module mips_load_run_ctrl #(
  parameter int          ADDR_W        = 10,
  parameter int          REG_AW        = 5,
  parameter int          NUM_INIT_REGS = 6,
  parameter int          NUM_DUMP_REGS = 6,
  parameter int          TIMEOUT       = 1024,
  parameter logic [5:0]  HALT_OP       = 6'h3f
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] prog_len,
  input  logic              ld_valid,
  input  logic [31:0]       ld_data,
  output logic              ld_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_addr,
  output logic [31:0]       rf_wdata,
  input  logic [31:0]       rf_rdata,
  output logic              cpu_run,
  input  logic              retire_valid,
  input  logic [5:0]        retire_op,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [REG_AW-1:0] dump_idx,
  output logic [31:0]       dump_data,
  output logic              done,
  output logic              timed_out,
  output logic [31:0]       run_cycles
);

  // DUMP_RD presents rf_addr, DUMP_CAP captures the synchronous read data,
  // DUMP_HOLD presents the word until the consumer takes it.
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_INIT, S_RUN, S_DUMP_RD, S_DUMP_CAP, S_DUMP_HOLD, S_DONE
  } state_t;

  localparam logic [REG_AW:0] INIT_N    = (REG_AW+1)'(NUM_INIT_REGS);
  localparam logic [REG_AW:0] DUMP_LAST = (REG_AW+1)'(NUM_DUMP_REGS - 1);
  localparam logic [31:0]     TIMEOUT_N = 32'(TIMEOUT);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   len_q, len_d;
  logic [ADDR_W-1:0]   wcnt_q, wcnt_d;
  logic [REG_AW:0]     kcnt_q, kcnt_d;
  logic [REG_AW:0]     kcnt_inc;
  logic [31:0]         run_cycles_q, run_cycles_d;
  logic                timed_out_q, timed_out_d;
  logic                done_q, done_d;
  logic                imem_we_q, imem_we_d;
  logic [ADDR_W-1:0]   imem_addr_q, imem_addr_d;
  logic [31:0]         imem_wdata_q, imem_wdata_d;
  logic                rf_we_q, rf_we_d;
  logic [REG_AW-1:0]   rf_addr_q, rf_addr_d;
  logic [31:0]         rf_wdata_q, rf_wdata_d;
  logic                cpu_run_q, cpu_run_d;
  logic                dump_valid_q, dump_valid_d;
  logic [REG_AW-1:0]   dump_idx_q, dump_idx_d;
  logic [31:0]         dump_data_q, dump_data_d;

  assign kcnt_inc   = kcnt_q + (REG_AW+1)'(1);

  assign ld_ready   = (state_q == S_LOAD);
  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign rf_we      = rf_we_q;
  assign rf_addr    = rf_addr_q;
  assign rf_wdata   = rf_wdata_q;
  assign cpu_run    = cpu_run_q;
  assign dump_valid = dump_valid_q;
  assign dump_idx   = dump_idx_q;
  assign dump_data  = dump_data_q;
  assign done       = done_q;
  assign timed_out  = timed_out_q;
  assign run_cycles = run_cycles_q;

  // State and output registers; reset clears everything and drops cpu_run.
  always_ff @(posedge clk1) begin
    if (rst) begin
      state_q      <= S_IDLE;
      len_q        <= '0;
      wcnt_q       <= '0;
      kcnt_q       <= '0;
      run_cycles_q <= '0;
      timed_out_q  <= 1'b0;
      done_q       <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      rf_we_q      <= 1'b0;
      rf_addr_q    <= '0;
      rf_wdata_q   <= '0;
      cpu_run_q    <= 1'b0;
      dump_valid_q <= 1'b0;
      dump_idx_q   <= '0;
      dump_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      wcnt_q       <= wcnt_d;
      kcnt_q       <= kcnt_d;
      run_cycles_q <= run_cycles_d;
      timed_out_q  <= timed_out_d;
      done_q       <= done_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      rf_we_q      <= rf_we_d;
      rf_addr_q    <= rf_addr_d;
      rf_wdata_q   <= rf_wdata_d;
      cpu_run_q    <= cpu_run_d;
      dump_valid_q <= dump_valid_d;
      dump_idx_q   <= dump_idx_d;
      dump_data_q  <= dump_data_d;
    end
  end

  // Next-state and next-output logic; strobes default low, data fields hold.
  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    wcnt_d       = wcnt_q;
    kcnt_d       = kcnt_q;
    run_cycles_d = run_cycles_q;
    timed_out_d  = timed_out_q;
    done_d       = done_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    rf_we_d      = 1'b0;
    rf_addr_d    = rf_addr_q;
    rf_wdata_d   = rf_wdata_q;
    cpu_run_d    = cpu_run_q;
    dump_valid_d = dump_valid_q;
    dump_idx_d   = dump_idx_q;
    dump_data_d  = dump_data_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d        = prog_len;
          wcnt_d       = '0;
          kcnt_d       = '0;
          done_d       = 1'b0;
          timed_out_d  = 1'b0;
          run_cycles_d = '0;
          state_d      = (prog_len != '0) ? S_LOAD : S_INIT;
        end
      end
      S_LOAD: begin
        if (ld_valid) begin
          imem_we_d    = 1'b1;
          imem_addr_d  = wcnt_q;
          imem_wdata_d = ld_data;
          wcnt_d       = wcnt_q + ADDR_W'(1);
          if (wcnt_q == len_q - ADDR_W'(1)) begin
            state_d = S_INIT;
            kcnt_d  = '0;
          end
        end
      end
      S_INIT: begin
        // One extra cycle after the last write so the core starts with a settled RF.
        if (kcnt_q == INIT_N) begin
          state_d   = S_RUN;
          cpu_run_d = 1'b1;
        end else begin
          rf_we_d    = 1'b1;
          rf_addr_d  = kcnt_q[REG_AW-1:0];
          rf_wdata_d = 32'(kcnt_q);
          kcnt_d     = kcnt_inc;
        end
      end
      S_RUN: begin
        // HALT is checked first so a HALT in the last budgeted cycle wins.
        run_cycles_d = run_cycles_q + 32'd1;
        if (retire_valid && (retire_op == HALT_OP)) begin
          state_d     = S_DUMP_RD;
          cpu_run_d   = 1'b0;
          timed_out_d = 1'b0;
          kcnt_d      = '0;
          rf_addr_d   = '0;
        end else if (run_cycles_q + 32'd1 == TIMEOUT_N) begin
          state_d     = S_DUMP_RD;
          cpu_run_d   = 1'b0;
          timed_out_d = 1'b1;
          kcnt_d      = '0;
          rf_addr_d   = '0;
        end
      end
      S_DUMP_RD: begin
        state_d = S_DUMP_CAP;
      end
      S_DUMP_CAP: begin
        dump_valid_d = 1'b1;
        dump_idx_d   = kcnt_q[REG_AW-1:0];
        dump_data_d  = rf_rdata;
        state_d      = S_DUMP_HOLD;
      end
      S_DUMP_HOLD: begin
        if (dump_ready) begin
          dump_valid_d = 1'b0;
          if (kcnt_q == DUMP_LAST) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            kcnt_d    = kcnt_inc;
            rf_addr_d = kcnt_inc[REG_AW-1:0];
            state_d   = S_DUMP_RD;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule
